aes_round_ctrl: RTL

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_round_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aes_round_ctrl
// Brief    : AES-128 round sequencer; key add and state register around an
//            external round function. Optional abort input: AES_ROUND_CTRL_ABORT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module aes_round_ctrl (
    input  logic         clk,
    input  logic         rst_n,
`ifdef AES_ROUND_CTRL_ABORT_EN
    input  logic         abort,
`endif
    input  logic         start,
    input  logic [127:0] plaintext,
    input  logic [127:0] newkey,
    input  logic [127:0] round_out,
    output logic [3:0]   counter_t,
    output logic         ok_add,
    output logic [127:0] state_out,
    output logic         last_round,
    output logic [127:0] ciphertext,
    output logic         done,
    output logic         busy
);

    localparam logic [3:0] c_first_round = 4'd1;
    localparam logic [3:0] c_last_round  = 4'd11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADD   = 3'd1,
        S_PULSE = 3'd2,
        S_STEP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [3:0]     r_counter;
    logic           r_ok_add;
    logic           r_done;
    logic [127:0]   r_pt;
    logic [127:0]   r_blk;
    logic [127:0]   r_ct;
    logic           w_abort;
    logic           w_abort_act;
    logic           w_last;
    logic [127:0]   w_add_in;

`ifdef AES_ROUND_CTRL_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_abort_act = w_abort && (r_state != S_IDLE);
    assign w_last      = (r_counter == c_last_round);
    assign w_add_in    = (r_counter == c_first_round) ? r_pt : round_out;

    always_comb begin
        w_next = r_state;
        if (w_abort_act) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start) w_next = S_ADD;
                S_ADD:   w_next = S_PULSE;
                S_PULSE: w_next = w_last ? S_DONE : S_STEP;
                S_STEP:  w_next = S_ADD;
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // ok_add clocks the key-expansion stage, so it comes straight off a flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_counter <= c_first_round;
            r_ok_add  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_ok_add <= (w_next == S_PULSE);
            r_done   <= (w_next == S_DONE);
            if (w_abort_act) begin
                r_counter <= c_first_round;
            end else if (r_state == S_STEP) begin
                r_counter <= r_counter + 4'd1;
            end else if (r_state == S_DONE) begin
                r_counter <= c_first_round;
            end
        end
    end

    // ciphertext loads on entry to DONE so it matches state_out during done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pt  <= '0;
            r_blk <= '0;
            r_ct  <= '0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_pt <= plaintext;
            end
            if ((r_state == S_ADD) && !w_abort_act) begin
                r_blk <= w_add_in ^ newkey;
            end
            if ((r_state == S_PULSE) && w_last && !w_abort_act) begin
                r_ct <= r_blk;
            end
        end
    end

    assign counter_t  = r_counter;
    assign ok_add     = r_ok_add;
    assign state_out  = r_blk;
    assign last_round = w_last;
    assign ciphertext = r_ct;
    assign done       = r_done;
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire
